kfmmc_command_scheduler: RTL and testbench
==========================================

# kfmmc_command_scheduler

Round-robin scheduler that shares the single MMC command-line engine (the KFMMC command IO block) between two requesters, such as the card-initialisation engine and the host register interface. It latches the winner's command descriptor, issues a one-cycle `start_command`, and tracks `command_busy` through completion. It also runs a watchdog that aborts a hung transaction through `reset_command_state`, then returns the response, CRC error and timeout status to the winner with a `done` pulse.

## Interface
- `TIMEOUT_CYCLES`, default 16'd50000: maximum cycles spent in WAIT_BUSY+RUN before abort; legal range 2..65535.

- `clock`  in  1  system clock; all state updates on falling edge (same edge as command IO)
- `reset`  in  1  reset; one clock; reset is synchronous and active-low (0 = reset)
- `request`  in  2  level request per requester; bit i = requester i
- `request_command`  in  96  requester i descriptor in [48*i+47:48*i]
- `request_enable_command_crc`  in  2  per-requester command CRC enable
- `request_enable_response_crc`  in  2  per-requester response CRC enable
- `request_response_length`  in  8  requester i response byte count in [4*i+3:4*i]
- `grant`  out  2  one-hot; high from issue until done inclusive
- `done`  out  2  one-cycle completion pulse to the winner
- `result_response`  out  56  captured response, valid from done until next done
- `result_response_error`  out  1  captured response CRC error
- `result_timeout`  out  1  transaction aborted by watchdog
- `start_command`  out  1  to command IO
- `command`  out  48  to command IO
- `enable_command_crc`  out  1  to command IO
- `enable_response_crc`  out  1  to command IO
- `response_length`  out  4  to command IO
- `reset_command_state`  out  1  abort pulse to command IO
- `command_busy`  in  1  from command IO
- `response`  in  56  from command IO
- `response_error`  in  1  from command IO

## Operation
- Reset values:
  - `grant`=0, `done`=0, `start_command`=0, `reset_command_state`=0
  - `command`=48'hFFFFFFFFFFFF, both CRC enables=0, `response_length`=0
  - `result_response`=56'hFFFFFFFFFFFFFF, `result_response_error`=0, `result_timeout`=0
  - `last_served`=1 (requester 0 wins first), state IDLE, watchdog=0
- All outputs are registered.
- **IDLE**: arbitrate only when `request`≠0 and `command_busy`=0.
  - If only one request is high, that requester wins.
  - If both are high, the requester ≠ `last_served` wins.
  - On winning: latch its descriptor fields onto the command IO outputs, set `grant`, set `start_command`=1, go to ISSUE.
- **ISSUE**: `start_command`←0, watchdog←0, go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `command_busy`=1, then go to RUN.
- **RUN**: wait for `command_busy`=0, then go to DONE_OK.
- **Watchdog**: increments every cycle in WAIT_BUSY and RUN.
  - If it equals TIMEOUT_CYCLES−1 while still waiting, the next state is ABORT.
  - Timeout takes priority over a simultaneous busy edge.
- **ABORT**: `reset_command_state`=1 for exactly one cycle, then go to DONE_TO.
- **DONE_OK**:
  - `result_response`←`response`, `result_response_error`←`response_error`, `result_timeout`←0.
  - Pulse `done[winner]`, `last_served`←winner, then go to IDLE.
- **DONE_TO**: `result_response`←all ones, `result_response_error`←0, `result_timeout`←1; pulse `done` and update `last_served` as in DONE_OK; `grant` clears on the following edge.
- **Descriptor hold**: `command`, CRC enables and `response_length` hold their latched values until the next arbitration.
- **Requester obligations**:
  - Keep `request` high until `done`; descriptor changes after grant are ignored.
  - Deassert `request` on the edge `done` is sampled; a request still high in the following IDLE cycle is treated as a new transaction.
- **Mid-operation reset**: everything returns to reset values; no `done` is issued.
- **Busy while idle**: if `command_busy` is high while in IDLE (e.g. command IO not yet idle after a separate reset), arbitration stalls until it falls.

## Timing
- Request high at IDLE edge n: `grant` and `start_command` high in cycle n+1 (ISSUE).
- `start_command` is exactly 1 cycle wide.
- Nominal flow: busy seen in WAIT_BUSY at cycle n+2 → RUN.
- Busy falling at edge m → `done` and results valid in cycle m+1.
- `grant` drops in cycle m+2; the next arbitration is possible at edge m+2.
- Timeout path: `reset_command_state` is asserted in cycle n+2+TIMEOUT_CYCLES, `done` in the cycle after that.
- Back-to-back: an idle-to-idle gap of 1 cycle (the IDLE arbitration cycle) between transactions.

## Test plan
- **Single request**: after reset, requester 0 requests command 48'h400000000095, resp len 0; busy model high 10 cycles → one `start_command` pulse; `command`=48'h400000000095; `done`=2'b01 one cycle after busy falls; `result_timeout`=0.
- **Simultaneous requests**: both request continuously for 4 transactions → grants alternate 01,10,01,10; never two `start_command` pulses without intervening busy fall.
- **Response capture**: model returns `response`=56'h003F_FFFF_FFFF_FF with `response_error`=1 at busy fall → `result_response` equals it, `result_response_error`=1 and held until the next `done`.
- **Watchdog**: TIMEOUT_CYCLES=8, busy stuck high → `reset_command_state` pulses once 8 cycles after WAIT_BUSY entry; `done` follows; `result_timeout`=1; `result_response`=all ones.
- **Busy never rises**: TIMEOUT_CYCLES=8 with `command_busy` never rising → same abort sequence; requester 1 queued meanwhile is granted afterwards.
- **Reset and busy-while-idle**: reset asserted in RUN → next cycle all outputs at reset values and no `done`; with `command_busy` held high in IDLE, a request is not granted until busy is low.

Source files
------------

// File: rtl/kfmmc_command_scheduler.sv
// kfmmc_command_scheduler
// Shares one MMC command IO engine between two requesters. In each transaction
// the scheduler arbitrates round-robin and latches the winner's descriptor. It
// then pulses start_command and follows command_busy until the command
// completes. A watchdog aborts a hung command through reset_command_state. At
// the end the scheduler returns response, CRC error and timeout status with a
// one-cycle done pulse.
//
// Ports:
//   clock, reset                 clock (state changes on the falling edge),
//                                synchronous active-low reset
//   request[1:0]                 level request per requester
//   request_command[95:0]        48-bit descriptor per requester
//   request_enable_*_crc[1:0]    per-requester CRC enables
//   request_response_length[7:0] 4-bit response byte count per requester
//   grant[1:0], done[1:0]        one-hot grant (issue..done), done pulse
//   result_*                     captured response / CRC error / timeout flag
//   start_command, command, enable_*_crc, response_length,
//   reset_command_state          outputs to the command IO block
//   command_busy, response, response_error
//                                inputs from the command IO block
module kfmmc_command_scheduler #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  request,
    input  logic [95:0] request_command,
    input  logic [1:0]  request_enable_command_crc,
    input  logic [1:0]  request_enable_response_crc,
    input  logic [7:0]  request_response_length,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [55:0] result_response,
    output logic        result_response_error,
    output logic        result_timeout,
    output logic        start_command,
    output logic [47:0] command,
    output logic        enable_command_crc,
    output logic        enable_response_crc,
    output logic [3:0]  response_length,
    output logic        reset_command_state,
    input  logic        command_busy,
    input  logic [55:0] response,
    input  logic        response_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_ABORT,
        ST_DONE_OK,
        ST_DONE_TO
    } state_t;

    // Watchdog value at which a still-pending transaction is aborted.
    localparam logic [15:0] WD_LAST = TIMEOUT_CYCLES - 16'd1;

    // Per-requester descriptor slices.
    logic [47:0] req_cmd [2];
    logic [3:0]  req_len [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_cmd[gi] = request_command[48*gi +: 48];
            assign req_len[gi] = request_response_length[4*gi +: 4];
        end
    endgenerate

    state_t      state_q, state_d;
    logic        last_served_q, last_served_d;
    logic        winner_q, winner_d;
    logic [15:0] watchdog_q, watchdog_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic        start_q, start_d;
    logic        rcs_q, rcs_d;
    logic [47:0] command_q, command_d;
    logic        ecc_q, ecc_d;
    logic        erc_q, erc_d;
    logic [3:0]  rlen_q, rlen_d;
    logic [55:0] res_q, res_d;
    logic        res_err_q, res_err_d;
    logic        res_to_q, res_to_d;
    logic        win_idx;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        winner_d      = winner_q;
        watchdog_d    = watchdog_q;
        grant_d       = grant_q;
        done_d        = 2'b00;
        start_d       = 1'b0;
        rcs_d         = 1'b0;
        command_d     = command_q;
        ecc_d         = ecc_q;
        erc_d         = erc_q;
        rlen_d        = rlen_q;
        res_d         = res_q;
        res_err_d     = res_err_q;
        res_to_d      = res_to_q;
        win_idx       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A busy command IO (still finishing from before) blocks arbitration.
                if (request != 2'b00 && !command_busy) begin
                    // On contention the requester not served last wins.
                    win_idx   = (request == 2'b11) ? ~last_served_q : request[1];
                    winner_d  = win_idx;
                    grant_d   = win_idx ? 2'b10 : 2'b01;
                    command_d = req_cmd[win_idx];
                    ecc_d     = request_enable_command_crc[win_idx];
                    erc_d     = request_enable_response_crc[win_idx];
                    rlen_d    = req_len[win_idx];
                    start_d   = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                watchdog_d = 16'd0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_RUN: begin
                watchdog_d = watchdog_q + 16'd1;
                // Timeout wins over a busy edge in the same cycle.
                if (watchdog_q == WD_LAST) begin
                    rcs_d   = 1'b1;
                    state_d = ST_ABORT;
                end else if (state_q == ST_WAIT_BUSY) begin
                    if (command_busy) begin
                        state_d = ST_RUN;
                    end
                end else if (!command_busy) begin
                    res_d         = response;
                    res_err_d     = response_error;
                    res_to_d      = 1'b0;
                    done_d        = grant_q;
                    last_served_d = winner_q;
                    state_d       = ST_DONE_OK;
                end
            end
            ST_ABORT: begin
                res_d         = {56{1'b1}};
                res_err_d     = 1'b0;
                res_to_d      = 1'b1;
                done_d        = grant_q;
                last_served_d = winner_q;
                state_d       = ST_DONE_TO;
            end
            ST_DONE_OK, ST_DONE_TO: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Falling edge: the command IO block updates on the same edge.
    always_ff @(negedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            winner_q      <= 1'b0;
            watchdog_q    <= 16'd0;
            grant_q       <= 2'b00;
            done_q        <= 2'b00;
            start_q       <= 1'b0;
            rcs_q         <= 1'b0;
            command_q     <= {48{1'b1}};
            ecc_q         <= 1'b0;
            erc_q         <= 1'b0;
            rlen_q        <= 4'd0;
            res_q         <= {56{1'b1}};
            res_err_q     <= 1'b0;
            res_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            winner_q      <= winner_d;
            watchdog_q    <= watchdog_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            start_q       <= start_d;
            rcs_q         <= rcs_d;
            command_q     <= command_d;
            ecc_q         <= ecc_d;
            erc_q         <= erc_d;
            rlen_q        <= rlen_d;
            res_q         <= res_d;
            res_err_q     <= res_err_d;
            res_to_q      <= res_to_d;
        end
    end

    assign grant                 = grant_q;
    assign done                  = done_q;
    assign start_command         = start_q;
    assign reset_command_state   = rcs_q;
    assign command               = command_q;
    assign enable_command_crc    = ecc_q;
    assign enable_response_crc   = erc_q;
    assign response_length       = rlen_q;
    assign result_response       = res_q;
    assign result_response_error = res_err_q;
    assign result_timeout        = res_to_q;

endmodule

// File: tb/tb_kfmmc_command_scheduler.sv
// tb_kfmmc_command_scheduler
// Directed stimulus. Each transaction pushes its expected completion record into
// a queue. A monitor pops one record on every done pulse and compares it. The
// DUT changes state on the falling clock edge. The bench drives inputs 1 ns
// after the falling edge and samples outputs on the rising edge.
module tb_kfmmc_command_scheduler;

    localparam int TO = 16;

    logic        clock;
    logic        reset;
    logic [1:0]  request;
    logic [95:0] request_command;
    logic [1:0]  request_enable_command_crc;
    logic [1:0]  request_enable_response_crc;
    logic [7:0]  request_response_length;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [55:0] result_response;
    logic        result_response_error;
    logic        result_timeout;
    logic        start_command;
    logic [47:0] command;
    logic        enable_command_crc;
    logic        enable_response_crc;
    logic [3:0]  response_length;
    logic        reset_command_state;
    logic        command_busy;
    logic [55:0] response;
    logic        response_error;

    // Busy comes from an automatic model or is forced by the main sequence.
    logic        model_busy;
    logic        hold_busy;
    int          model_mode;     // 0: answer start_command, 1: ignore it
    int          busy_len;
    logic [55:0] model_resp;
    logic        model_err;

    assign command_busy = model_busy | hold_busy;

    kfmmc_command_scheduler #(.TIMEOUT_CYCLES(16'(TO))) dut (
        .clock                       (clock),
        .reset                       (reset),
        .request                     (request),
        .request_command             (request_command),
        .request_enable_command_crc  (request_enable_command_crc),
        .request_enable_response_crc (request_enable_response_crc),
        .request_response_length     (request_response_length),
        .grant                       (grant),
        .done                        (done),
        .result_response             (result_response),
        .result_response_error       (result_response_error),
        .result_timeout              (result_timeout),
        .start_command               (start_command),
        .command                     (command),
        .enable_command_crc          (enable_command_crc),
        .enable_response_crc         (enable_response_crc),
        .response_length             (response_length),
        .reset_command_state         (reset_command_state),
        .command_busy                (command_busy),
        .response                    (response),
        .response_error              (response_error)
    );

    typedef struct packed {
        logic [1:0]  who;
        logic [55:0] resp;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_start_cyc = 0;
    int   last_done_cyc = 0;
    int   last_rcs_cyc = 0;
    int   rcs_count = 0;
    logic prev_start = 1'b0;
    logic prev_busy = 1'b0;
    logic pending_start = 1'b0;

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish before 100000 ns");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] w, input logic [55:0] r, input logic e, input logic t);
        exp_q.push_back(exp_t'{who: w, resp: r, err: e, tmo: t});
    endtask

    task automatic set_req(input int idx, input logic [47:0] cmd, input logic ecc,
                           input logic erc, input logic [3:0] len);
        request_command[48*idx +: 48]       = cmd;
        request_enable_command_crc[idx]     = ecc;
        request_enable_response_crc[idx]    = erc;
        request_response_length[4*idx +: 4] = len;
        request[idx]                        = 1'b1;
    endtask

    task automatic wait_start(input int limit);
        int t = 0;
        @(posedge clock);
        while (!start_command && t < limit) begin
            @(posedge clock);
            t++;
        end
        chk("start_seen", 64'(start_command), 64'd1);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        @(posedge clock);
        while (done == 2'b00 && t < limit) begin
            @(posedge clock);
            t++;
        end
        chk("done_seen", 64'(done != 2'b00), 64'd1);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_start_rcs"}, 64'({start_command, reset_command_state}), 64'd0);
        chk({tag, "_command"}, 64'(command), 64'hFFFF_FFFF_FFFF);
        chk({tag, "_crc_len"}, 64'({enable_command_crc, enable_response_crc, response_length}), 64'd0);
        chk({tag, "_result"}, 64'(result_response), 64'h00FF_FFFF_FFFF_FFFF);
        chk({tag, "_err_to"}, 64'({result_response_error, result_timeout}), 64'd0);
    endtask

    // Busy model: rises one cycle after start_command, stays high busy_len cycles,
    // then falls while presenting the response.
    initial begin
        model_busy     = 1'b0;
        response       = {56{1'b1}};
        response_error = 1'b0;
        forever begin
            @(posedge clock);
            if (start_command && model_mode == 0) begin
                @(negedge clock);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(negedge clock);
                #1;
                model_busy     = 1'b0;
                response       = model_resp;
                response_error = model_err;
            end
        end
    end

    // Monitor and scoreboard.
    always @(posedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        if (!reset) begin
            pending_start = 1'b0;
            prev_start    = 1'b0;
        end else begin
            if (start_command) begin
                chk("start_one_cycle", 64'(prev_start), 64'd0);
                chk("start_after_busy_fall", 64'(pending_start), 64'd0);
                pending_start  = 1'b1;
                last_start_cyc = cyc;
            end
            if (prev_busy && !command_busy) pending_start = 1'b0;
            if (reset_command_state) begin
                pending_start = 1'b0;
                rcs_count++;
                last_rcs_cyc = cyc;
            end
            if (done != 2'b00) begin
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b, required no done", done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_who", 64'(done), 64'(e.who));
                    chk("grant_at_done", 64'(grant), 64'(e.who));
                    chk("result_response", 64'(result_response), 64'(e.resp));
                    chk("result_response_error", 64'(result_response_error), 64'(e.err));
                    chk("result_timeout", 64'(result_timeout), 64'(e.tmo));
                end
            end
            prev_start = start_command;
        end
        prev_busy = command_busy;
    end

    initial begin
        int rcs_before;
        reset                       = 1'b0;
        request                     = 2'b00;
        request_command             = '0;
        request_enable_command_crc  = 2'b00;
        request_enable_response_crc = 2'b00;
        request_response_length     = 8'd0;
        hold_busy                   = 1'b0;
        model_mode                  = 0;
        busy_len                    = 10;
        model_resp                  = 56'h01_2345_6789_ABCD;
        model_err                   = 1'b0;

        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        check_reset("por");

        // Single request from requester 0, busy high 10 cycles.
        @(negedge clock);
        #1;
        set_req(0, 48'h4000_0000_0095, 1'b1, 1'b0, 4'd0);
        push_exp(2'b01, 56'h01_2345_6789_ABCD, 1'b0, 1'b0);
        @(negedge clock);
        @(posedge clock);
        #1;
        chk("t1_start", 64'(start_command), 64'd1);
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_command", 64'(command), 64'h4000_0000_0095);
        chk("t1_crc_len", 64'({enable_command_crc, enable_response_crc, response_length}), 64'h20);
        @(posedge clock);
        #1 chk("t1_start_low", 64'(start_command), 64'd0);
        wait_done(40);
        chk("t1_done_latency", 64'(last_done_cyc - last_start_cyc), 64'd12);
        @(negedge clock);
        #1 request[0] = 1'b0;
        @(posedge clock);
        #1;
        chk("t1_grant_drop", 64'(grant), 64'd0);
        chk("t1_command_hold", 64'(command), 64'h4000_0000_0095);

        // Requester 1: response with CRC error; descriptor change after grant ignored.
        model_resp = 56'h00_3FFF_FFFF_FFFF;
        model_err  = 1'b1;
        busy_len   = 3;
        @(negedge clock);
        #1;
        set_req(1, 48'h4D12_3456_789A, 1'b0, 1'b1, 4'd6);
        push_exp(2'b10, 56'h00_3FFF_FFFF_FFFF, 1'b1, 1'b0);
        wait_start(10);
        chk("t2_grant", 64'(grant), 64'd2);
        chk("t2_crc_len", 64'({enable_command_crc, enable_response_crc, response_length}), 64'h16);
        request_command[95:48] = 48'h0;
        @(posedge clock);
        #1 chk("t2_command_latched", 64'(command), 64'h4D12_3456_789A);
        wait_done(40);
        @(negedge clock);
        #1 request[1] = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("t2_resp_hold", 64'(result_response), 64'h00_3FFF_FFFF_FFFF);
        chk("t2_err_hold", 64'(result_response_error), 64'd1);

        // Busy falls one cycle before the watchdog limit: normal completion.
        model_resp = 56'hAA_5555_0000_1234;
        model_err  = 1'b0;
        busy_len   = TO - 2;
        @(negedge clock);
        #1 set_req(0, 48'h4800_0001_AA87, 1'b1, 1'b1, 4'd6);
        push_exp(2'b01, 56'hAA_5555_0000_1234, 1'b0, 1'b0);
        wait_done(60);
        chk("t3_done_latency", 64'(last_done_cyc - last_start_cyc), 64'(TO));
        @(negedge clock);
        #1 request[0] = 1'b0;

        // Busy falls exactly at the limit: timeout wins.
        busy_len   = TO - 1;
        rcs_before = rcs_count;
        @(negedge clock);
        #1 set_req(0, 48'h4800_0001_AA87, 1'b1, 1'b1, 4'd6);
        push_exp(2'b01, {56{1'b1}}, 1'b0, 1'b1);
        wait_done(60);
        chk("t4_rcs_latency", 64'(last_rcs_cyc - last_start_cyc), 64'(TO + 1));
        chk("t4_done_latency", 64'(last_done_cyc - last_start_cyc), 64'(TO + 2));
        chk("t4_rcs_count", 64'(rcs_count - rcs_before), 64'd1);
        @(negedge clock);
        #1 request[0] = 1'b0;

        // Busy stuck high on requester 1.
        model_mode = 1;
        rcs_before = rcs_count;
        @(negedge clock);
        #1 set_req(1, 48'h5100_0000_0055, 1'b1, 1'b1, 4'd6);
        push_exp(2'b10, {56{1'b1}}, 1'b0, 1'b1);
        wait_start(10);
        @(negedge clock);
        #1 hold_busy = 1'b1;
        wait_done(60);
        chk("t5_rcs_latency", 64'(last_rcs_cyc - last_start_cyc), 64'(TO + 1));
        chk("t5_done_latency", 64'(last_done_cyc - last_start_cyc), 64'(TO + 2));
        chk("t5_rcs_count", 64'(rcs_count - rcs_before), 64'd1);
        @(negedge clock);
        #1;
        request[1] = 1'b0;
        hold_busy  = 1'b0;

        // Busy never rises; requester 1 queued meanwhile is served afterwards.
        @(negedge clock);
        #1 set_req(0, 48'h4000_0000_0095, 1'b0, 1'b0, 4'd0);
        push_exp(2'b01, {56{1'b1}}, 1'b0, 1'b1);
        model_resp = 56'h12_0000_0000_0021;
        busy_len   = 4;
        push_exp(2'b10, 56'h12_0000_0000_0021, 1'b0, 1'b0);
        wait_start(10);
        @(negedge clock);
        #1 set_req(1, 48'h5200_0000_0011, 1'b1, 1'b1, 4'd6);
        wait_done(60);
        chk("t6_rcs_latency", 64'(last_rcs_cyc - last_start_cyc), 64'(TO + 1));
        @(negedge clock);
        #1;
        request[0] = 1'b0;
        model_mode = 0;
        wait_start(10);
        chk("t6_queued_grant", 64'(grant), 64'd2);
        chk("t6_queued_command", 64'(command), 64'h5200_0000_0011);
        wait_done(40);
        @(negedge clock);
        #1 request[1] = 1'b0;

        // Fresh reset, then both requesters continuously for 4 transactions.
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
        model_resp = 56'h77_0000_0000_0077;
        busy_len   = 4;
        push_exp(2'b01, 56'h77_0000_0000_0077, 1'b0, 1'b0);
        push_exp(2'b10, 56'h77_0000_0000_0077, 1'b0, 1'b0);
        push_exp(2'b01, 56'h77_0000_0000_0077, 1'b0, 1'b0);
        push_exp(2'b10, 56'h77_0000_0000_0077, 1'b0, 1'b0);
        set_req(0, 48'h4000_0000_0095, 1'b1, 1'b0, 4'd0);
        set_req(1, 48'h5200_0000_0011, 1'b1, 1'b1, 4'd6);
        for (int k = 0; k < 4; k++) wait_done(40);
        @(negedge clock);
        #1 request = 2'b00;

        // Reset in the middle of RUN: no done, reset values next cycle.
        busy_len = 10;
        @(negedge clock);
        #1 set_req(0, 48'h4000_0000_0095, 1'b1, 1'b0, 4'd0);
        wait_start(10);
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        reset   = 1'b0;
        request = 2'b00;
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 check_reset("mid_run");
        repeat (15) @(posedge clock);

        // Busy high while idle stalls arbitration.
        model_resp = 56'h33_0000_0000_0033;
        busy_len   = 2;
        @(negedge clock);
        #1;
        hold_busy = 1'b1;
        set_req(0, 48'h4000_0000_0095, 1'b1, 1'b0, 4'd0);
        push_exp(2'b01, 56'h33_0000_0000_0033, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1 chk("busy_idle_no_grant", 64'({grant, start_command}), 64'd0);
        end
        @(negedge clock);
        #1 hold_busy = 1'b0;
        wait_start(10);
        chk("busy_idle_grant", 64'(grant), 64'd1);
        wait_done(40);
        @(negedge clock);
        #1 request[0] = 1'b0;

        repeat (4) @(posedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
